// File: rtl/fifo_stream_reader.sv
// Drains an attached FIFO into a valid/ready stream in batches of batch_size words,
// flushing a partial batch once the FIFO has sat non-empty but short for TIMEOUT cycles.
module fifo_stream_reader #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 16,
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             clear,
   input  logic [CW-1:0]    batch_size,
   input  logic             fifo_empty,
   input  logic [CW-1:0]    fifo_count,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             fifo_ren,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic             busy,
   output logic [15:0]      batches_sent
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    remaining_q, remaining_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             m_valid_q, m_valid_d;
   logic [WIDTH-1:0] m_data_q, m_data_d;
   logic             m_last_q, m_last_d;
   logic [15:0]      batches_q, batches_d;
   logic [CW-1:0]    eff_batch;
   logic             pop;
   logic             handshake;

   always_comb begin
      eff_batch = batch_size;
      if (batch_size == '0) begin
         eff_batch = CW'(1);
      end else if (batch_size > CW'(DEPTH)) begin
         eff_batch = CW'(DEPTH);
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      timer_d     = timer_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      m_last_d    = m_last_q;
      batches_d   = batches_q;
      pop         = 1'b0;
      handshake   = m_valid_q && m_ready;

      // A pop in the same cycle overrides this by reloading the output register.
      if (handshake) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
         if (m_last_q) begin
            batches_d = batches_q + 16'd1;
         end
      end

      case (state_q)
         IDLE: begin
            if (fifo_count >= eff_batch) begin
               state_d     = STREAM;
               remaining_d = eff_batch;
               timer_d     = '0;
            end else if (fifo_count == '0) begin
               timer_d = '0;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d     = STREAM;
               remaining_d = fifo_count;
               timer_d     = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         STREAM: begin
            pop = !fifo_empty && (remaining_q != '0) && (!m_valid_q || m_ready);
            if (pop) begin
               m_data_d    = fifo_rdata;
               m_valid_d   = 1'b1;
               m_last_d    = (remaining_q == CW'(1));
               remaining_d = remaining_q - CW'(1);
               if (remaining_q == CW'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (handshake && m_last_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over everything, including a pop or a last-beat handshake.
      if (clear) begin
         state_d     = IDLE;
         m_valid_d   = 1'b0;
         m_last_d    = 1'b0;
         remaining_d = '0;
         timer_d     = '0;
         batches_d   = batches_q;
         pop         = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         timer_q     <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_last_q    <= 1'b0;
         batches_q   <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         timer_q     <= timer_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_last_q    <= m_last_d;
         batches_q   <= batches_d;
      end
   end

   assign fifo_ren     = pop;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_last       = m_last_q;
   assign busy         = (state_q != IDLE);
   assign batches_sent = batches_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a small FIFO model feeds the DUT and a
// negedge monitor logs pops and stream beats for the checks in the main sequence.
module tb_fifo_stream_reader;

   localparam int WIDTH   = 8;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 16;
   localparam int CW      = 4;

   logic             CLK = 1'b0;
   logic             nRST = 1'b0;
   logic             clear = 1'b0;
   logic [CW-1:0]    batch_size = '0;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_ren;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [WIDTH-1:0] m_data;
   logic             m_last;
   logic             busy;
   logic [15:0]      batches_sent;

   fifo_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .nRST(nRST), .clear(clear), .batch_size(batch_size),
      .fifo_empty(fifo_empty), .fifo_count(fifo_count), .fifo_rdata(fifo_rdata),
      .fifo_ren(fifo_ren), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .busy(busy), .batches_sent(batches_sent)
   );

   always #5 CLK = ~CLK;

   // FIFO model (16 slots, bench never holds more than DEPTH words)
   logic [WIDTH-1:0] fmem [16];
   int unsigned      frd = 0;
   int unsigned      fwr = 0;
   logic             push_en = 1'b0;
   logic [WIDTH-1:0] push_data = '0;

   assign fifo_count = CW'(fwr - frd);
   assign fifo_empty = (fwr == frd);
   assign fifo_rdata = fmem[frd[3:0]];

   always @(posedge CLK) begin
      if (push_en) begin
         fmem[fwr[3:0]] <= push_data;
         fwr <= fwr + 1;
      end
      if (fifo_ren) frd <= frd + 1;
   end

   // Monitor
   int         cyc = 0, pops = 0, underruns = 0, bp_viol = 0, stall_viol = 0, stalls = 0, beat_n = 0;
   logic [7:0] beat_data [64];
   logic       beat_last [64];
   int         beat_cyc [64];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;

   always @(negedge CLK) begin
      cyc <= cyc + 1;
      if (fifo_ren) pops <= pops + 1;
      if (fifo_ren && fifo_empty) underruns <= underruns + 1;
      if (fifo_ren && m_valid && !m_ready) bp_viol <= bp_viol + 1;
      if (nRST && prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
         stall_viol <= stall_viol + 1;
      prev_stall <= m_valid && !m_ready;
      if (m_valid && !m_ready) stalls <= stalls + 1;
      prev_data <= m_data;
      prev_last <= m_last;
      if (m_valid && m_ready && beat_n < 64) begin
         beat_data[beat_n] <= m_data;
         beat_last[beat_n] <= m_last;
         beat_cyc[beat_n]  <= cyc;
         beat_n <= beat_n + 1;
      end
   end

   int checks = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_word(input logic [7:0] d);
      push_en = 1'b1;
      push_data = d;
      step();
      push_en = 1'b0;
   endtask

   task automatic wait_batches(input int target, input int budget, input string tag);
      int n = 0;
      while (int'(batches_sent) != target && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(batches_sent), 32'(target));
      step();
      step();
   endtask

   initial begin
      int b, p, s, bv, sv, n;

      // Reset state
      step();
      step();
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_last", 32'(m_last), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_batches", 32'(batches_sent), 0);
      check("rst_fifo_ren", 32'(fifo_ren), 0);
      nRST = 1'b1;
      step();

      // Full batch of 4 with m_ready held high
      batch_size = 4'd4;
      m_ready = 1'b1;
      b = beat_n;
      p = pops;
      for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
      wait_batches(1, 40, "full_batches");
      check("full_beats", 32'(beat_n - b), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("full_data%0d", i), 32'(beat_data[b + i]), 32'(8'hA0 + 8'(i)));
         check($sformatf("full_last%0d", i), 32'(beat_last[b + i]), 32'(i == 3));
      end
      check("full_span", 32'(beat_cyc[b + 3] - beat_cyc[b]), 3);
      check("full_pops", 32'(pops - p), 4);
      check("full_busy", 32'(busy), 0);

      // Timeout flush: first word lands in cycle k, timer is 15 in cycle k+15,
      // so the first pop is in cycle k+16.
      b = beat_n;
      p = pops;
      push_word(8'hB0);
      push_word(8'hB1);
      n = 1;
      while (!fifo_ren && n < 40) begin
         step();
         n++;
      end
      check("tmo_gap", 32'(n), 16);
      check("tmo_nopop", 32'(pops - p), 0);
      wait_batches(2, 20, "tmo_batches");
      check("tmo_beats", 32'(beat_n - b), 2);
      check("tmo_data0", 32'(beat_data[b]), 32'(8'hB0));
      check("tmo_data1", 32'(beat_data[b + 1]), 32'(8'hB1));
      check("tmo_last0", 32'(beat_last[b]), 0);
      check("tmo_last1", 32'(beat_last[b + 1]), 1);

      // Backpressure: m_ready toggles every cycle
      batch_size = 4'd3;
      m_ready = 1'b0;
      b = beat_n;
      bv = bp_viol;
      sv = stall_viol;
      s = stalls;
      for (int i = 0; i < 3; i++) push_word(8'hC0 + 8'(i));
      n = 0;
      while (batches_sent != 16'd3 && n < 60) begin
         m_ready = ~m_ready;
         step();
         n++;
      end
      m_ready = 1'b1;
      check("bp_batches", 32'(batches_sent), 3);
      step();
      check("bp_beats", 32'(beat_n - b), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_data%0d", i), 32'(beat_data[b + i]), 32'(8'hC0 + 8'(i)));
         check($sformatf("bp_last%0d", i), 32'(beat_last[b + i]), 32'(i == 2));
      end
      check("bp_ren_stalled", 32'(bp_viol - bv), 0);
      check("bp_stable", 32'(stall_viol - sv), 0);
      check("bp_stalls_seen", 32'((stalls - s) > 0), 1);

      // Clamp: 0 -> 1 beat, 15 -> DEPTH beats
      batch_size = 4'd0;
      b = beat_n;
      push_word(8'hD0);
      wait_batches(4, 30, "clamp0_batches");
      check("clamp0_beats", 32'(beat_n - b), 1);
      check("clamp0_data", 32'(beat_data[b]), 32'(8'hD0));
      check("clamp0_last", 32'(beat_last[b]), 1);
      batch_size = 4'd15;
      b = beat_n;
      p = pops;
      for (int i = 0; i < 8; i++) push_word(8'hE0 + 8'(i));
      wait_batches(5, 40, "clamp15_batches");
      check("clamp15_beats", 32'(beat_n - b), 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("clamp15_data%0d", i), 32'(beat_data[b + i]), 32'(8'hE0 + 8'(i)));
         check($sformatf("clamp15_last%0d", i), 32'(beat_last[b + i]), 32'(i == 7));
      end
      check("clamp15_pops", 32'(pops - p), 8);

      // Clear after 2 of 4 beats: F2 is in flight and dropped, F3 stays queued
      batch_size = 4'd4;
      b = beat_n;
      p = pops;
      for (int i = 0; i < 4; i++) push_word(8'hF0 + 8'(i));
      n = 0;
      while ((beat_n - b) < 2 && n < 40) begin
         step();
         n++;
      end
      check("clr_reach2", 32'(beat_n - b), 2);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_m_valid", 32'(m_valid), 0);
      check("clr_m_last", 32'(m_last), 0);
      check("clr_busy", 32'(busy), 0);
      check("clr_batches", 32'(batches_sent), 5);
      check("clr_fifo_ren", 32'(fifo_ren), 0);
      check("clr_pops", 32'(pops - p), 3);
      check("clr_count", 32'(fifo_count), 1);
      b = beat_n;
      for (int i = 0; i < 10; i++) step();
      check("clr_nopop", 32'(pops - p), 3);
      wait_batches(6, 30, "clr_flush_batches");
      check("clr_flush_data", 32'(beat_data[b]), 32'(8'hF3));
      check("clr_flush_last", 32'(beat_last[b]), 1);

      // Reset mid-stream with a stalled beat
      m_ready = 1'b0;
      p = pops;
      for (int i = 0; i < 4; i++) push_word(8'h90 + 8'(i));
      n = 0;
      while (!m_valid && n < 40) begin
         step();
         n++;
      end
      check("rst2_valid_before", 32'(m_valid), 1);
      nRST = 1'b0;
      #1;
      check("rst2_m_valid", 32'(m_valid), 0);
      check("rst2_m_last", 32'(m_last), 0);
      check("rst2_m_data", 32'(m_data), 0);
      check("rst2_busy", 32'(busy), 0);
      check("rst2_batches", 32'(batches_sent), 0);
      check("rst2_fifo_ren", 32'(fifo_ren), 0);
      step();
      step();
      step();
      check("rst2_pops", 32'(pops - p), 1);
      check("rst2_count", 32'(fifo_count), 3);
      nRST = 1'b1;
      m_ready = 1'b1;
      b = beat_n;
      wait_batches(1, 60, "rst2_resume_batches");
      check("rst2_resume_beats", 32'(beat_n - b), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst2_data%0d", i), 32'(beat_data[b + i]), 32'(8'h91 + 8'(i)));
         check($sformatf("rst2_last%0d", i), 32'(beat_last[b + i]), 32'(i == 2));
      end
      check("underruns", 32'(underruns), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of one FIFO entry / stream beat.
REQ-002 SHALL have parameter: DEPTH, 8, depth of the attached FIFO (power of 2, >=1); CW = $clog2(DEPTH+1).
REQ-003 SHALL have parameter: TIMEOUT, 16, idle cycles before a partial batch is flushed (>=1).
REQ-004 SHALL have ports as follows; reset is nRST, asynchronous, active-low; clock is CLK.
REQ-005 SHALL have ports: CLK  in  1  clock; nRST  in  1  async active-low reset.
REQ-006 SHALL have port: clear  in  1  sync abort, return to IDLE.
REQ-007 SHALL have port: batch_size  in  CW  words per batch; 0 treated as 1, >DEPTH treated as DEPTH.
REQ-008 SHALL have ports: fifo_empty  in  1;  fifo_count  in  CW;  fifo_rdata  in  WIDTH (head-of-FIFO data, valid combinationally when !fifo_empty).
REQ-009 SHALL have port: fifo_ren  out  1  pop strobe to FIFO.
REQ-010 SHALL have ports: m_valid  out  1;  m_ready  in  1;  m_data  out  WIDTH;  m_last  out  1 (last beat of batch).
REQ-011 SHALL have ports: busy  out  1 (state != IDLE);  batches_sent  out  16 (completed batches, wraps).

Function
REQ-012 SHALL implement FSM states IDLE, STREAM, DRAIN.
REQ-013 SHALL, in IDLE with eff_batch = clamped batch_size, go to STREAM and latch remaining = eff_batch when fifo_count >= eff_batch.
REQ-014 SHALL run an idle timer in IDLE: increment while 0 < fifo_count < eff_batch, reset to 0 when fifo_count == 0 or on leaving IDLE.
REQ-015 SHALL, when the timer reaches TIMEOUT-1 with fifo_count > 0, go to STREAM and latch remaining = fifo_count (partial flush).
REQ-016 SHALL, in STREAM, drive fifo_ren = !fifo_empty && remaining != 0 && (!m_valid || m_ready), combinationally.
REQ-017 SHALL, on a pop, register m_data <= fifo_rdata, m_valid <= 1, m_last <= (remaining == 1), and decrement remaining; the beat appears one cycle after fifo_ren.
REQ-018 SHALL, on handshake (m_valid && m_ready) without a same-cycle pop, clear m_valid and m_last next cycle.
REQ-019 SHALL hold m_data/m_last stable while m_valid && !m_ready (no beat dropped or altered under backpressure).
REQ-020 SHALL sustain one beat per cycle when m_ready is held high.
REQ-021 SHALL move STREAM -> DRAIN when remaining reaches 0, and DRAIN -> IDLE on the handshake of the m_last beat.
REQ-022 SHALL increment batches_sent by 1, modulo 2^16, on each m_last handshake.
REQ-023 SHALL never assert fifo_ren while fifo_empty is 1 (no underrun), including after an external clear of the FIFO mid-batch; in that case it waits in STREAM.
REQ-024 SHALL never assert fifo_ren in IDLE or DRAIN.
REQ-025 SHALL, on clear, next cycle: state IDLE, m_valid = 0, m_last = 0, remaining = 0, timer = 0; batches_sent is unchanged; clear has priority over all other events.
REQ-026 SHALL ignore batch_size changes after remaining is latched until the next IDLE.
REQ-027 SHALL let new FIFO writes during STREAM not extend the current batch.

Reset
REQ-028 SHALL, on nRST low, asynchronously set: state IDLE, fifo_ren 0, m_valid 0, m_data 0, m_last 0, busy 0, batches_sent 0, timer 0, remaining 0.
REQ-029 SHALL, on reset asserted mid-batch, discard the in-flight beat with no further pops; operation resumes from IDLE after release.

Verification
REQ-030 SHALL verify full batch: batch_size=4, push 4 words A0..A3, m_ready=1 -> 4 consecutive beats A0..A3, m_last only on A3, batches_sent=1, 4 pops total.
REQ-031 SHALL verify timeout flush: TIMEOUT=16, batch_size=4, push 2 words -> no pop for 15 cycles, then 2 beats with m_last on 2nd, batches_sent=1.
REQ-032 SHALL verify backpressure: batch_size=3, m_ready toggling 0/1 every cycle -> data order preserved, m_data stable while stalled, fifo_ren never asserted while m_valid && !m_ready.
REQ-033 SHALL verify clamp: batch_size=0 with 1 word -> immediate 1-beat batch with m_last; batch_size=15 (DEPTH=8) with 8 words -> 8-beat batch.
REQ-034 SHALL verify clear: clear mid-batch after 2 of 4 beats -> m_valid=0 next cycle, busy=0, batches_sent unchanged, no fifo_ren until a new trigger.
REQ-035 SHALL verify reset mid-stream: nRST low with m_valid=1 -> all outputs 0 immediately, no fifo_ren while nRST low.
